acc_frame_sched: RTL

Controller that sequences the sample-accumulation datapath. It clears the accumulator, admits exactly CGES samples per frame through a valid/ready handshake, and waits one cycle for the accumulator to settle. It then captures the accumulated sum and presents it downstream under a valid/ready handshake. It sits between the sample source and the accumulator core and is gated by the top-level start/fin controls.

---
 rtl/acc_frame_sched.sv | 87 ++++++++
 1 files changed

// File: rtl/acc_frame_sched.sv
// Frame sequencer for the sample accumulator: clear, admit CGES samples,
// settle one cycle, then hand the captured sum downstream.
module acc_frame_sched #(
    parameter int BITS = 32,
    parameter int CGES = 50,
    localparam int CW = $clog2(CGES),
    localparam int W  = $clog2(CGES) + BITS
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          fin,
    input  logic          smp_valid,
    output logic          smp_ready,
    output logic          acc_clr,
    output logic          acc_en,
    input  logic [W-1:0]  acc_sum,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  result,
    output logic [CW-1:0] smp_cnt,
    output logic [15:0]   frame_cnt,
    output logic          busy,
    output logic          aborted
);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, HOLD} state_t;

    state_t state, state_nxt;
    logic   last_smp;
    logic   hshake;
    logic   abort_now;

    assign last_smp  = acc_en && (smp_cnt == CW'(CGES - 1));
    assign hshake    = (state == HOLD) && res_ready;
    assign abort_now = fin && ((state == CLEAR) || (state == ACCUM));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !fin) state_nxt = CLEAR;
            CLEAR:   state_nxt = fin ? IDLE : ACCUM;
            ACCUM: begin
                if (fin)           state_nxt = IDLE;
                else if (last_smp) state_nxt = FLUSH;
            end
            FLUSH:   state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = (start && !fin) ? CLEAR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // fin outranks a sample in ACCUM, so ready drops in the same cycle
    always_comb begin
        smp_ready = (state == ACCUM) && !fin;
        acc_en    = smp_valid && smp_ready;
        acc_clr   = (state == CLEAR);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            smp_cnt   <= '0;
            frame_cnt <= '0;
            result    <= '0;
            res_valid <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            aborted <= abort_now;
            if (state == CLEAR || abort_now || last_smp) smp_cnt <= '0;
            else if (acc_en)                             smp_cnt <= smp_cnt + 1'b1;
            if (state == FLUSH) begin
                result    <= acc_sum;
                res_valid <= 1'b1;
            end else if (hshake) begin
                res_valid <= 1'b0;
            end
            if (hshake) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule
